// File: rtl/row_collapse_stg_pkg.sv
// Shared definitions for the row-collapse stage: word layout, default sizing and FSM states.
package row_collapse_stg_pkg;
   localparam int DATA_PRECISION  = 32;
   localparam int BITS_ROW_IDX    = 8;
   localparam int DEF_DATA_WIDTH  = BITS_ROW_IDX + DATA_PRECISION + 1;
   localparam int DEF_BITS_OUT_Q  = 2;
   localparam int DEF_ADD_LAT     = 3;

   localparam int VALID_BIT = 0;
   localparam int VALUE_LSB = 1;
   localparam int VALUE_MSB = DATA_PRECISION;
   localparam int ROW_LSB   = DATA_PRECISION + 1;
   localparam int ROW_MSB   = DEF_DATA_WIDTH - 1;

   typedef struct packed {
      logic [BITS_ROW_IDX-1:0]   row;
      logic [DATA_PRECISION-1:0] value;
      logic                      valid;
   } word_t;

   typedef enum logic [1:0] {ACCUM, WAIT_ADD, FLUSH, DONE} state_t;
endpackage

// File: rtl/row_collapse_stg_adder.sv
// Pipelined single-precision float adder; denormals flush to zero, round to nearest even.
module adder_pipe_w_ctrl #(
   parameter int LAT = 3
) (
   input  logic        clk,
   input  logic        rst_b,
   input  logic        ena,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] sum
);
   logic [31:0]        big, sml, sum_comb;
   logic [7:0]         e_diff;
   logic [26:0]        m_big, m_sml, m_aln, m_lost, m_diff, m_norm;
   logic [27:0]        m_sum;
   logic [24:0]        m_rnd;
   logic signed [10:0] e_res;
   logic [4:0]         lz;
   logic               eff_sub, round_up;

   always_comb begin
      big      = (a[30:0] >= b[30:0]) ? a : b;
      sml      = (a[30:0] >= b[30:0]) ? b : a;
      eff_sub  = big[31] ^ sml[31];
      e_diff   = big[30:23] - sml[30:23];
      m_big    = (big[30:23] != 8'd0) ? {1'b1, big[22:0], 3'b000} : 27'd0;
      m_sml    = (sml[30:23] != 8'd0) ? {1'b1, sml[22:0], 3'b000} : 27'd0;
      m_lost   = '0;
      m_aln    = '0;
      // Mantissa layout: hidden bit, 23 fraction bits, guard, round, sticky.
      if (e_diff > 8'd26) begin
         m_aln = {26'd0, |m_sml};
      end else begin
         m_lost = m_sml & ~({27{1'b1}} << e_diff);
         m_aln  = (m_sml >> e_diff) | {26'd0, |m_lost};
      end
      m_sum  = {1'b0, m_big} + {1'b0, m_aln};
      m_diff = m_big - m_aln;
      lz     = 5'd0;
      e_res  = $signed({3'b000, big[30:23]});
      m_norm = m_sum[26:0];
      if (eff_sub) begin
         for (int i = 0; i < 27; i++) begin
            if (m_diff[i]) lz = 5'(26 - i);
         end
         m_norm = m_diff << lz;
         e_res  = e_res - $signed({6'd0, lz});
      end else if (m_sum[27]) begin
         m_norm = m_sum[27:1] | {26'd0, m_sum[0]};
         e_res  = e_res + 11'sd1;
      end
      round_up = m_norm[2] & (m_norm[1] | m_norm[0] | m_norm[3]);
      m_rnd    = {1'b0, m_norm[26:3]} + {24'd0, round_up};
      if (m_rnd[24]) e_res = e_res + 11'sd1;
      if (big[30:23] == 8'hff)
         sum_comb = big;
      else if (m_norm == 27'd0 || e_res <= 11'sd0)
         sum_comb = 32'd0;
      else if (e_res >= 11'sd255)
         sum_comb = {big[31], 8'hff, 23'd0};
      else
         sum_comb = {big[31], e_res[7:0], m_rnd[24] ? 23'd0 : m_rnd[22:0]};
   end

   generate
      for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
         logic [31:0] stage_reg;
         logic [31:0] stage_in;
         if (gi == 0) begin : g_first
            assign stage_in = sum_comb;
         end else begin : g_next
            assign stage_in = g_stage[gi-1].stage_reg;
         end
         always_ff @(posedge clk or negedge rst_b) begin
            if (!rst_b)   stage_reg <= '0;
            else if (ena) stage_reg <= stage_in;
         end
      end
   endgenerate

   assign sum = g_stage[LAT-1].stage_reg;
endmodule

// File: rtl/row_collapse_stg_fifo.sv
// Small first-word-fall-through FIFO; the head reads as zero while empty.
module sfifo #(
   parameter int DSIZE = 41,
   parameter int ASIZE = 2
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             wr_en,
   input  logic [DSIZE-1:0] wdata,
   input  logic             rd_en,
   output logic [DSIZE-1:0] rdata,
   output logic             full,
   output logic             empty
);
   localparam int DEPTH = 1 << ASIZE;

   logic [DSIZE-1:0] mem [DEPTH];
   logic [ASIZE:0]   wr_ptr_reg, rd_ptr_reg;
   logic             do_wr, do_rd;

   assign empty = (wr_ptr_reg == rd_ptr_reg);
   assign full  = (wr_ptr_reg[ASIZE] != rd_ptr_reg[ASIZE]) &&
                  (wr_ptr_reg[ASIZE-1:0] == rd_ptr_reg[ASIZE-1:0]);
   assign do_wr = wr_en & ~full;
   assign do_rd = rd_en & ~empty;
   assign rdata = empty ? '0 : mem[rd_ptr_reg[ASIZE-1:0]];

   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr_reg[ASIZE-1:0]] <= wdata;
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
      end else begin
         if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
   end
endmodule

// File: rtl/row_collapse_stg.sv
// Merges consecutive same-row partial sums into one final sum per row and queues finished rows.
module row_collapse_stg
   import row_collapse_stg_pkg::*;
#(
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int BITS_OUT_Q = DEF_BITS_OUT_Q,
   parameter int ADD_LAT    = DEF_ADD_LAT
) (
   input  logic                  clk,
   input  logic                  rst_b,
   input  logic                  en_global,
   input  logic                  data_ended,
   input  logic [DATA_WIDTH-1:0] di,
   input  logic                  prev_stg_rd_ready,
   output logic                  prev_stg_rd_en,
   input  logic                  next_stg_rd_en,
   output logic                  out_q_rd_ready,
   output logic [DATA_WIDTH-1:0] do_collapse_out_q,
   output logic                  done
);
   localparam int CNT_W = $clog2(ADD_LAT + 1);

   word_t                     di_w, hold_reg, hold_next;
   state_t                    state_reg, state_next;
   logic [CNT_W-1:0]          cnt_reg, cnt_next;
   logic [DATA_PRECISION-1:0] add_sum;
   logic                      fifo_full, fifo_empty, push, pop_up;

   assign di_w           = word_t'(di);
   assign pop_up         = en_global & prev_stg_rd_ready & (state_reg == ACCUM) & ~fifo_full;
   assign prev_stg_rd_en = pop_up;
   assign out_q_rd_ready = ~fifo_empty;
   assign done           = (state_reg == DONE);

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_reg <= ACCUM;
         hold_reg  <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         hold_reg  <= hold_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      hold_next  = hold_reg;
      cnt_next   = cnt_reg;
      push       = 1'b0;
      case (state_reg)
         ACCUM: begin
            if (pop_up) begin
               if (di_w.valid) begin
                  if (!hold_reg.valid) begin
                     hold_next = di_w;
                  end else if (hold_reg.row != di_w.row) begin
                     push      = 1'b1;
                     hold_next = di_w;
                  end else begin
                     // Adder samples hold/di this cycle; result lands after ADD_LAT enabled cycles.
                     cnt_next   = CNT_W'(ADD_LAT);
                     state_next = WAIT_ADD;
                  end
               end
            end else if (en_global && data_ended && !prev_stg_rd_ready) begin
               state_next = FLUSH;
            end
         end
         WAIT_ADD: begin
            if (en_global) begin
               if (cnt_reg == CNT_W'(1)) begin
                  hold_next.value = add_sum;
                  cnt_next        = '0;
                  state_next      = ACCUM;
               end else begin
                  cnt_next = cnt_reg - 1'b1;
               end
            end
         end
         FLUSH: begin
            if (en_global) begin
               if (!hold_reg.valid) begin
                  state_next = DONE;
               end else if (!fifo_full) begin
                  push       = 1'b1;
                  hold_next  = '0;
                  state_next = DONE;
               end
            end
         end
         DONE: state_next = DONE;
         default: state_next = ACCUM;
      endcase
   end

   adder_pipe_w_ctrl #(.LAT(ADD_LAT)) u_adder (
      .clk   (clk),
      .rst_b (rst_b),
      .ena   (en_global),
      .a     (hold_reg.value),
      .b     (di_w.value),
      .sum   (add_sum)
   );

   sfifo #(.DSIZE(DATA_WIDTH), .ASIZE(BITS_OUT_Q)) u_out_q (
      .clk   (clk),
      .rst_b (rst_b),
      .wr_en (push),
      .wdata (DATA_WIDTH'(hold_reg)),
      .rd_en (en_global & next_stg_rd_en),
      .rdata (do_collapse_out_q),
      .full  (fifo_full),
      .empty (fifo_empty)
   );
endmodule

// File: tb/tb_row_collapse_stg.sv
// Bench for row_collapse_stg: directed scenarios plus random traffic against a row-merge model.
module tb_row_collapse_stg;
   import row_collapse_stg_pkg::*;

   localparam int W     = DEF_DATA_WIDTH;
   localparam int DEPTH = 1 << DEF_BITS_OUT_Q;

   logic         clk = 1'b0;
   logic         rst_b = 1'b0;
   logic         en_global = 1'b0;
   logic         data_ended = 1'b0;
   logic [W-1:0] di = '0;
   logic         prev_stg_rd_ready = 1'b0;
   logic         prev_stg_rd_en;
   logic         next_stg_rd_en = 1'b0;
   logic         out_q_rd_ready;
   logic [W-1:0] do_collapse_out_q;
   logic         done;

   always #5 clk = ~clk;

   row_collapse_stg dut (
      .clk               (clk),
      .rst_b             (rst_b),
      .en_global         (en_global),
      .data_ended        (data_ended),
      .di                (di),
      .prev_stg_rd_ready (prev_stg_rd_ready),
      .prev_stg_rd_en    (prev_stg_rd_en),
      .next_stg_rd_en    (next_stg_rd_en),
      .out_q_rd_ready    (out_q_rd_ready),
      .do_collapse_out_q (do_collapse_out_q),
      .done              (done)
   );

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic [W-1:0] up_q[$];
   logic [W-1:0] exp_q[$];
   logic [W-1:0] got_q[$];
   int           pop_log[$];

   bit                      open_v = 0;
   logic [BITS_ROW_IDX-1:0] open_row = '0;
   real                     open_sum = 0.0;

   task automatic check(string name, logic [63:0] act, logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   function automatic logic [31:0] to_f32(real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (r == 0.0) return 32'h0;
      return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
   endfunction

   function automatic logic [W-1:0] mk_word(logic [BITS_ROW_IDX-1:0] row, real v, logic vld);
      return {row, to_f32(v), vld};
   endfunction

   task automatic drive();
      prev_stg_rd_ready = (up_q.size() > 0);
      di = (up_q.size() > 0) ? up_q[0] : '0;
   endtask

   // Model: a row closes when the next valid word carries a different row index.
   task automatic put(logic [BITS_ROW_IDX-1:0] row, real v, bit vld);
      up_q.push_back(mk_word(row, v, vld));
      if (vld) begin
         if (!open_v) begin
            open_v = 1; open_row = row; open_sum = v;
         end else if (row == open_row) begin
            open_sum = open_sum + v;
         end else begin
            exp_q.push_back(mk_word(open_row, open_sum, 1'b1));
            open_row = row; open_sum = v;
         end
      end
      drive();
   endtask

   task automatic model_flush();
      if (open_v) exp_q.push_back(mk_word(open_row, open_sum, 1'b1));
      open_v = 0;
   endtask

   // One clock: look at outputs on the falling edge, then update stimulus just after the rising edge.
   task automatic tick();
      bit do_pop, do_out;
      @(negedge clk);
      do_pop = prev_stg_rd_en;
      do_out = rst_b && en_global && next_stg_rd_en && out_q_rd_ready;
      if (!rst_b)
         check("reset_outputs", {prev_stg_rd_en, out_q_rd_ready, done, do_collapse_out_q}, 64'd0);
      if (prev_stg_rd_en)
         check("pop_legal", {en_global, up_q.size() > 0}, 2'b11);
      if (do_out) begin
         got_q.push_back(do_collapse_out_q);
         if (exp_q.size() == 0) check("unexpected_output", do_collapse_out_q, 64'd0);
         else check("out_word", do_collapse_out_q, exp_q.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
      if (do_pop && up_q.size() > 0) begin
         pop_log.push_back(cyc);
         void'(up_q.pop_front());
      end
      drive();
   endtask

   task automatic do_reset();
      rst_b = 1'b0;
      up_q.delete(); exp_q.delete(); got_q.delete(); pop_log.delete();
      open_v = 0;
      data_ended = 1'b0;
      drive();
      repeat (3) tick();
      rst_b = 1'b1;
      en_global = 1'b1;
      next_stg_rd_en = 1'b1;
      tick();
   endtask

   task automatic finish_run(string name);
      model_flush();
      data_ended = 1'b1;
      en_global = 1'b1;
      next_stg_rd_en = 1'b1;
      for (int i = 0; i < 5000 && !(done && !out_q_rd_ready); i++) tick();
      check({name, "_done"}, done, 1);
      check({name, "_drained"}, exp_q.size(), 0);
   endtask

   task automatic wait_pops(int n);
      for (int i = 0; i < 50 && pop_log.size() < n; i++) tick();
      check("pop_wait", pop_log.size() >= n, 1);
   endtask

   initial begin
      #20000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: three partials on one row
      do_reset();
      put(3, 1.0, 1); put(3, 2.0, 1); put(3, 4.0, 1);
      finish_run("t1");
      check("t1_count", got_q.size(), 1);
      if (got_q.size() >= 1) check("t1_word", got_q[0], {8'd3, 32'h40E00000, 1'b1});
      if (pop_log.size() == 3) begin
         check("t1_gap_first", pop_log[1] - pop_log[0], 1);
         check("t1_gap_merge", pop_log[2] - pop_log[1], DEF_ADD_LAT + 1);
      end else check("t1_pops", pop_log.size(), 3);

      // 2: rows 1,2,2,5
      do_reset();
      put(1, 1.0, 1); put(2, 2.0, 1); put(2, 3.0, 1); put(5, 0.5, 1);
      finish_run("t2");
      check("t2_count", got_q.size(), 3);
      if (got_q.size() == 3) begin
         check("t2_w0", got_q[0], {8'd1, 32'h3F800000, 1'b1});
         check("t2_w1", got_q[1], {8'd2, 32'h40A00000, 1'b1});
         check("t2_w2", got_q[2], {8'd5, 32'h3F000000, 1'b1});
      end
      if (pop_log.size() == 4) check("t2_no_pop_in_wait", pop_log[3] - pop_log[2], DEF_ADD_LAT + 1);

      // 3: invalid words interleaved
      do_reset();
      put(4, 1.5, 1); put(4, 9.0, 0); put(4, 2.5, 1); put(6, 3.0, 0);
      finish_run("t3");
      check("t3_count", got_q.size(), 1);
      if (got_q.size() >= 1) check("t3_word", got_q[0], {8'd4, 32'h40800000, 1'b1});
      check("t3_all_popped", pop_log.size(), 4);

      // 4: output queue backpressure
      do_reset();
      next_stg_rd_en = 1'b0;
      for (int r = 10; r < 17; r++) put(8'(r), real'(r) * 0.25, 1);
      repeat (30) tick();
      check("t4_pops_when_full", pop_log.size(), DEPTH + 1);
      check("t4_stalled", {prev_stg_rd_en, out_q_rd_ready}, 2'b01);
      finish_run("t4");
      check("t4_count", got_q.size(), 7);

      // 5: enable dropped during an add
      do_reset();
      put(7, 1.0, 1); put(7, 2.0, 1); put(7, 1.0, 1);
      wait_pops(2);
      en_global = 1'b0;
      repeat (5) tick();
      check("t5_frozen_pops", pop_log.size(), 2);
      en_global = 1'b1;
      wait_pops(3);
      if (pop_log.size() == 3) check("t5_gap", pop_log[2] - pop_log[1], DEF_ADD_LAT + 6);
      finish_run("t5");
      check("t5_count", got_q.size(), 1);
      if (got_q.size() >= 1) check("t5_word", got_q[0], {8'd7, 32'h40800000, 1'b1});

      // 6: reset in the middle of a merge
      do_reset();
      put(8, 1.0, 1); put(8, 2.0, 1);
      wait_pops(2);
      tick();
      do_reset();
      put(9, 1.0, 1);
      finish_run("t6");
      check("t6_count", got_q.size(), 1);
      if (got_q.size() >= 1) check("t6_word", got_q[0], {8'd9, 32'h3F800000, 1'b1});

      // 7: random traffic
      do_reset();
      begin
         logic [BITS_ROW_IDX-1:0] row;
         int nout;
         row = 0;
         nout = 0;
         for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 9) < 6) row = 8'($urandom_range(0, 3));
            put(row, real'(int'($urandom_range(0, 64)) - 32) / 4.0, $urandom_range(0, 9) != 0);
            en_global = ($urandom_range(0, 9) != 0);
            next_stg_rd_en = ($urandom_range(0, 9) < 7);
            repeat ($urandom_range(1, 3)) tick();
         end
         nout = exp_q.size() + got_q.size() + (open_v ? 1 : 0);
         finish_run("rand");
         check("rand_count", got_q.size(), nout);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
